// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg
// Shared processor package for the multicycle controller.
// Holds the main FSM state codes, the Op field codes, the ALUSrcB and
// ResultSrc select constants, the bundled control-word type and a helper
// that turns a state into its Moore output word.
package mainfsm_pkg;

    // State codes; 11..15 are unused and treated as illegal.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    // Instruction Op field codes (Op=11 is undefined).
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALU B-input selects.
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus selects.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Every control output of the FSM, kept together so it can be
    // registered as one word.
    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       branch;
        logic       regw;
        logic       memw;
        logic       aluop;
    } ctrl_t;

    // Output decode: everything starts at 0 and each state raises only
    // the controls it needs, so illegal codes fall through to all-zero.
    function automatic ctrl_t decodectrl(statetype s);
        ctrl_t c;
        c           = '0;
        c.alusrcb   = SRCB_WD;
        c.resultsrc = RES_ALUOUT;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            EXECUTER: begin
                c.aluop = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb = SRCB_IMM;
                c.aluop   = 1'b1;
            end
            ALUWB: begin
                c.regw = 1'b1;
            end
            MEMADR: begin
                c.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                c.adrsrc = 1'b1;
            end
            MEMWB: begin
                c.regw      = 1'b1;
                c.resultsrc = RES_DATA;
            end
            MEMWR: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            BRANCH: begin
                c.branch    = 1'b1;
                c.alusrcb   = SRCB_IMM;
                c.resultsrc = RES_ALURESULT;
            end
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mainfsm_if.sv
// mainfsm_if
// Bundle between the instruction decoder side and the main FSM.
//   Op, Funct   : instruction fields, driven by the master (datapath)
//   IRWrite .. ALUOp : control outputs, driven by the slave (mainfsm)
//   state_o     : current state code, for debug
interface mainfsm_if;
    import mainfsm_pkg::*;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       Branch;
    logic       RegW;
    logic       MemW;
    logic       ALUOp;
    logic [3:0] state_o;

    modport master (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  NextPC, Branch, RegW, MemW, ALUOp, state_o
    );

    modport slave (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output NextPC, Branch, RegW, MemW, ALUOp, state_o
    );

endinterface

// File: rtl/mainfsm.sv
// mainfsm
// Main control FSM of the multicycle processor (Moore machine).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset; forces FETCH
//   bus   : mainfsm_if.slave -- Op/Funct in, control word and state_o out
// Latency FETCH to FETCH: load 5, store 4, data-processing 4,
// branch 3, undefined 3.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mainfsm_if.slave   bus
);

    statetype state;
    statetype nextstate;
    ctrl_t    ctrl;

    // Next-state logic. Op and Funct are only looked at in DECODE and
    // MEMADR, so their values in any other state cannot steer the machine.
    // Illegal codes land in default and go back to FETCH.
    always_comb begin
        nextstate = FETCH;
        case (state)
            FETCH:  nextstate = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_DP:   nextstate = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  nextstate = MEMADR;
                    OP_BR:   nextstate = BRANCH;
                    default: nextstate = UNKNOWN;
                endcase
            end
            MEMADR:   nextstate = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    nextstate = MEMWB;
            EXECUTER: nextstate = ALUWB;
            EXECUTEI: nextstate = ALUWB;
            default:  nextstate = FETCH;
        endcase
    end

    // State and output registers. The output word is decoded from the
    // state being entered, so it always matches the state register and
    // has no path from Op/Funct in the same cycle. Reset wins over any
    // transition, which drops a pending RegW/MemW of the current
    // instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= decodectrl(FETCH);
        end else begin
            state <= nextstate;
            ctrl  <= decodectrl(nextstate);
        end
    end

    assign bus.IRWrite   = ctrl.irwrite;
    assign bus.AdrSrc    = ctrl.adrsrc;
    assign bus.ALUSrcA   = ctrl.alusrca;
    assign bus.ALUSrcB   = ctrl.alusrcb;
    assign bus.ResultSrc = ctrl.resultsrc;
    assign bus.NextPC    = ctrl.nextpc;
    assign bus.Branch    = ctrl.branch;
    assign bus.RegW      = ctrl.regw;
    assign bus.MemW      = ctrl.memw;
    assign bus.ALUOp     = ctrl.aluop;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm
// Self-checking bench for mainfsm. A reference model derives the expected
// state walk of an instruction from its Op/Funct, and a per-state table
// gives the expected control word. Inputs change on the falling edge and
// outputs are sampled there too.
module tb_mainfsm;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mainfsm_if bus();

    mainfsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected control word per state code, packed as
    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], NextPC, Branch, RegW, MemW, ALUOp}
    logic [11:0] outtbl [0:10];

    logic [3:0]  obsstate [$];
    logic [11:0] obsout   [$];
    int          expseq   [$];

    function automatic logic [11:0] dutouts();
        return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.NextPC, bus.Branch, bus.RegW, bus.MemW, bus.ALUOp};
    endfunction

    // Reference model: the state walk of one instruction, FETCH to FETCH.
    function automatic void build_expected(input logic [1:0] op, input logic [5:0] funct);
        expseq.delete();
        expseq.push_back(0);
        expseq.push_back(1);
        case (op)
            2'b00: begin
                expseq.push_back(funct[5] ? 7 : 6);
                expseq.push_back(8);
            end
            2'b01: begin
                expseq.push_back(2);
                if (funct[0]) begin
                    expseq.push_back(3);
                    expseq.push_back(4);
                end else begin
                    expseq.push_back(5);
                end
            end
            2'b10:   expseq.push_back(9);
            default: expseq.push_back(10);
        endcase
        expseq.push_back(0);
    endfunction

    function automatic int spec_latency(input logic [1:0] op, input logic [5:0] funct);
        if (op == 2'b01) return funct[0] ? 5 : 4;
        if (op == 2'b00) return 4;
        return 3;
    endfunction

    // Runs one instruction starting at a falling edge in FETCH and records
    // state/outputs each cycle until FETCH comes round again (max 8 cycles).
    // With scramble set, Op/Funct are randomised outside DECODE/MEMADR.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input bit scramble);
        obsstate.delete();
        obsout.delete();
        for (int c = 0; c < 8; c++) begin
            obsstate.push_back(bus.state_o);
            obsout.push_back(dutouts());
            if (c > 0 && bus.state_o == 4'd0) break;
            if (!scramble || bus.state_o == 4'd1 || bus.state_o == 4'd2) begin
                bus.Op    = op;
                bus.Funct = funct;
            end else begin
                bus.Op    = 2'($urandom);
                bus.Funct = 6'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.Op    = 2'b00;
        bus.Funct = 6'b000000;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.state_o !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold_state: got %0d want 0", bus.state_o);
            end
            checks++;
            if (dutouts() !== outtbl[0]) begin
                errors++;
                $display("[TB] FAIL reset_hold_outs: got %h want %h", dutouts(), outtbl[0]);
            end
        end
        reset = 1'b0;
        checks++;
        if (bus.state_o !== 4'd0 || bus.IRWrite !== 1'b1 || bus.NextPC !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_free: got state=%0d IRWrite=%b NextPC=%b want 0/1/1",
                     bus.state_o, bus.IRWrite, bus.NextPC);
        end
    endtask

    task automatic test_load();
        run_instr(2'b01, 6'b000001, 1'b0);
        build_expected(2'b01, 6'b000001);
        checks++;
        if (obsstate.size() - 1 != 5) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d want 5", obsstate.size() - 1);
        end
        for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
            checks++;
            if (obsstate[i] !== 4'(expseq[i])) begin
                errors++;
                $display("[TB] FAIL load_state[%0d]: got %0d want %0d", i, obsstate[i], expseq[i]);
            end
            checks++;
            if (obsout[i] !== outtbl[expseq[i]]) begin
                errors++;
                $display("[TB] FAIL load_outs[%0d]: got %h want %h", i, obsout[i], outtbl[expseq[i]]);
            end
        end
    endtask

    task automatic test_store();
        run_instr(2'b01, 6'b000000, 1'b0);
        build_expected(2'b01, 6'b000000);
        checks++;
        if (obsstate.size() - 1 != 4) begin
            errors++;
            $display("[TB] FAIL store_latency: got %0d want 4", obsstate.size() - 1);
        end
        for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
            checks++;
            if (obsstate[i] !== 4'(expseq[i])) begin
                errors++;
                $display("[TB] FAIL store_state[%0d]: got %0d want %0d", i, obsstate[i], expseq[i]);
            end
            checks++;
            if (obsout[i] !== outtbl[expseq[i]]) begin
                errors++;
                $display("[TB] FAIL store_outs[%0d]: got %h want %h", i, obsout[i], outtbl[expseq[i]]);
            end
        end
    endtask

    // ADD immediate, then a register-form data-processing instruction.
    task automatic test_dataproc();
        logic [5:0] fn [2];
        fn[0] = 6'b101000;
        fn[1] = 6'b001000;
        for (int k = 0; k < 2; k++) begin
            run_instr(2'b00, fn[k], 1'b0);
            build_expected(2'b00, fn[k]);
            checks++;
            if (obsstate.size() - 1 != 4) begin
                errors++;
                $display("[TB] FAIL dp_latency: got %0d want 4", obsstate.size() - 1);
            end
            for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
                checks++;
                if (obsstate[i] !== 4'(expseq[i])) begin
                    errors++;
                    $display("[TB] FAIL dp_state[%0d]: got %0d want %0d", i, obsstate[i], expseq[i]);
                end
                checks++;
                if (obsout[i] !== outtbl[expseq[i]]) begin
                    errors++;
                    $display("[TB] FAIL dp_outs[%0d]: got %h want %h", i, obsout[i], outtbl[expseq[i]]);
                end
            end
        end
    endtask

    task automatic test_branch_undef();
        logic [1:0] ops [2];
        ops[0] = 2'b10;
        ops[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            run_instr(ops[k], 6'b010101, 1'b0);
            build_expected(ops[k], 6'b010101);
            checks++;
            if (obsstate.size() - 1 != 3) begin
                errors++;
                $display("[TB] FAIL br_latency: op=%0d got %0d want 3", ops[k], obsstate.size() - 1);
            end
            for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
                checks++;
                if (obsstate[i] !== 4'(expseq[i])) begin
                    errors++;
                    $display("[TB] FAIL br_state[%0d]: got %0d want %0d", i, obsstate[i], expseq[i]);
                end
                checks++;
                if (obsout[i] !== outtbl[expseq[i]]) begin
                    errors++;
                    $display("[TB] FAIL br_outs[%0d]: got %h want %h", i, obsout[i], outtbl[expseq[i]]);
                end
            end
        end
    endtask

    // Store walked into MEMWR, then reset; MemW must drop at the edge.
    task automatic test_reset_midinstr();
        bus.Op    = 2'b01;
        bus.Funct = 6'b000000;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd5 || bus.MemW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reach_memwr: got state=%0d MemW=%b want 5/1", bus.state_o, bus.MemW);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.state_o !== 4'd0 || bus.MemW !== 1'b0 || bus.RegW !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_reset: got state=%0d MemW=%b RegW=%b want 0/0/0",
                         bus.state_o, bus.MemW, bus.RegW);
            end
            checks++;
            if (dutouts() !== outtbl[0]) begin
                errors++;
                $display("[TB] FAIL mid_reset_outs: got %h want %h", dutouts(), outtbl[0]);
            end
        end
        reset = 1'b0;
    endtask

    // ADD immediate with Op/Funct scrambled outside DECODE/MEMADR.
    task automatic test_ignore_inputs();
        for (int k = 0; k < 3; k++) begin
            run_instr(2'b00, 6'b101000, 1'b1);
            build_expected(2'b00, 6'b101000);
            for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
                checks++;
                if (obsstate[i] !== 4'(expseq[i])) begin
                    errors++;
                    $display("[TB] FAIL ignore_state[%0d]: got %0d want %0d", i, obsstate[i], expseq[i]);
                end
            end
            checks++;
            if (obsstate.size() != expseq.size()) begin
                errors++;
                $display("[TB] FAIL ignore_len: got %0d want %0d", obsstate.size(), expseq.size());
            end
        end
    endtask

    // Random instructions, back to back, with scrambled don't-care inputs.
    task automatic test_random();
        logic [1:0] op;
        logic [5:0] fn;
        logic [11:0] o;
        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            run_instr(op, fn, 1'b1);
            build_expected(op, fn);
            checks++;
            if (obsstate.size() - 1 != spec_latency(op, fn)) begin
                errors++;
                $display("[TB] FAIL rnd_latency: op=%0d fn=%b got %0d want %0d",
                         op, fn, obsstate.size() - 1, spec_latency(op, fn));
            end
            for (int i = 0; i < expseq.size() && i < obsstate.size(); i++) begin
                checks++;
                if (obsstate[i] !== 4'(expseq[i])) begin
                    errors++;
                    $display("[TB] FAIL rnd_state[%0d]: op=%0d fn=%b got %0d want %0d",
                             i, op, fn, obsstate[i], expseq[i]);
                end
                checks++;
                if (obsout[i] !== outtbl[expseq[i]]) begin
                    errors++;
                    $display("[TB] FAIL rnd_outs[%0d]: got %h want %h", i, obsout[i], outtbl[expseq[i]]);
                end
                o = obsout[i];
                checks++;
                if ((32'(o[11]) + 32'(o[2]) + 32'(o[1])) > 1 || (o[4] && o[3])) begin
                    errors++;
                    $display("[TB] FAIL rnd_exclusive[%0d]: got outs %h want at most one write and not NextPC+Branch",
                             i, o);
                end
            end
        end
    endtask

    initial begin
        outtbl[0]  = 12'b1_0_1_10_10_1_0_0_0_0;
        outtbl[1]  = 12'b0_0_1_10_10_0_0_0_0_0;
        outtbl[2]  = 12'b0_0_0_01_00_0_0_0_0_0;
        outtbl[3]  = 12'b0_1_0_00_00_0_0_0_0_0;
        outtbl[4]  = 12'b0_0_0_00_01_0_0_1_0_0;
        outtbl[5]  = 12'b0_1_0_00_00_0_0_0_1_0;
        outtbl[6]  = 12'b0_0_0_00_00_0_0_0_0_1;
        outtbl[7]  = 12'b0_0_0_01_00_0_0_0_0_1;
        outtbl[8]  = 12'b0_0_0_00_00_0_0_1_0_0;
        outtbl[9]  = 12'b0_0_0_01_10_0_1_0_0_0;
        outtbl[10] = 12'b0_0_0_00_00_0_0_0_0_0;

        test_reset();
        test_load();
        test_store();
        test_dataproc();
        test_branch_undef();
        test_reset_midinstr();
        test_ignore_inputs();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
